// File: rtl/sfft_frame_reader.sv
// SFFT output reader: captures the full bin vector into a two-bank buffer
// and streams the first OUT_BINS bins one beat at a time over valid/ready.
module sfft_frame_reader #(
  parameter int NFFT       = 256,
  parameter int nFFT       = 8,
  parameter int DATA_WIDTH = 24,
  parameter int OUT_BINS   = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] SFFT_In [NFFT],
  input  logic                  InputValid,
  output logic [DATA_WIDTH-1:0] BinOut,
  output logic [nFFT-1:0]       BinIndex,
  output logic                  BinValid,
  input  logic                  BinReady,
  output logic                  FrameStart,
  output logic                  FrameEnd,
  output logic [15:0]           FrameCount,
  output logic [7:0]            DroppedCount,
  output logic                  Overflow,
  output logic                  Busy
);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  localparam logic [nFFT-1:0] LAST = nFFT'(OUT_BINS - 1);

  logic [DATA_WIDTH-1:0] mem [2][NFFT];

  state_t                state;
  state_t                stateNext;
  logic [1:0]            full;
  logic [1:0]            fullNext;
  logic                  wrBank;
  logic                  wrBankNext;
  logic                  rdBank;
  logic                  rdBankNext;
  logic [nFFT-1:0]       idx;
  logic [nFFT-1:0]       idxNext;
  logic                  ivPrev;

  logic                  trigger;
  logic                  xfer;
  logic                  lastXfer;
  logic                  wrFree;
  logic                  capture;
  logic                  drop;

  logic [15:0]           fcNext;
  logic [7:0]            dcNext;
  logic                  ovNext;
  logic [DATA_WIDTH-1:0] binNext;
  logic                  validNext;
  logic                  startNext;
  logic                  endNext;

  assign Busy = |full;

  // Next-state: read sequencing, bank bookkeeping and the registered beat
  always_comb begin
    stateNext  = state;
    fullNext   = full;
    wrBankNext = wrBank;
    rdBankNext = rdBank;
    idxNext    = idx;
    fcNext     = FrameCount;
    dcNext     = DroppedCount;
    ovNext     = Overflow;

    trigger  = InputValid && !ivPrev;
    xfer     = BinValid && BinReady;
    lastXfer = xfer && (idx == LAST);

    unique case (state)
      IDLE: begin
        if (full[rdBank]) begin
          stateNext = STREAM;
          idxNext   = '0;
        end
      end
      STREAM: begin
        if (xfer) begin
          if (idx == LAST) begin
            fullNext[rdBank] = 1'b0;
            rdBankNext       = ~rdBank;
            idxNext          = '0;
            fcNext           = FrameCount + 16'd1;
            stateNext        = full[~rdBank] ? STREAM : IDLE;
          end else begin
            idxNext = idx + nFFT'(1);
          end
        end
      end
      default: stateNext = IDLE;
    endcase

    // A bank released by this edge's final beat is free for capture
    wrFree  = !full[wrBank] || (lastXfer && (rdBank == wrBank));
    capture = trigger && wrFree;
    drop    = trigger && !wrFree;

    if (capture) begin
      fullNext[wrBank] = 1'b1;
      wrBankNext       = ~wrBank;
    end

    if (drop) begin
      ovNext = 1'b1;
      if (DroppedCount != 8'hFF) begin
        dcNext = DroppedCount + 8'd1;
      end
    end

    validNext = (stateNext == STREAM);
    binNext   = validNext ? mem[rdBankNext][idxNext] : '0;
    startNext = validNext && (idxNext == '0);
    endNext   = validNext && (idxNext == LAST);
  end

  // State, bookkeeping and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      full         <= '0;
      wrBank       <= 1'b0;
      rdBank       <= 1'b0;
      idx          <= '0;
      ivPrev       <= 1'b0;
      FrameCount   <= '0;
      DroppedCount <= '0;
      Overflow     <= 1'b0;
      BinValid     <= 1'b0;
      BinOut       <= '0;
      BinIndex     <= '0;
      FrameStart   <= 1'b0;
      FrameEnd     <= 1'b0;
    end else begin
      state        <= stateNext;
      full         <= fullNext;
      wrBank       <= wrBankNext;
      rdBank       <= rdBankNext;
      idx          <= idxNext;
      ivPrev       <= InputValid;
      FrameCount   <= fcNext;
      DroppedCount <= dcNext;
      Overflow     <= ovNext;
      BinValid     <= validNext;
      BinOut       <= binNext;
      BinIndex     <= idxNext;
      FrameStart   <= startNext;
      FrameEnd     <= endNext;
    end
  end

  // Frame buffer write: whole vector lands in the free bank on capture
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int k = 0; k < NFFT; k++) begin
        mem[wrBank][k] <= SFFT_In[k];
      end
    end
  end

endmodule

// File: tb/tb_sfft_frame_reader.sv
// Scoreboard bench for sfft_frame_reader: frames pushed on capture,
// a negedge monitor pops and compares every accepted beat.
module tb_sfft_frame_reader;

  localparam int NFFT = 8;
  localparam int NB   = 3;
  localparam int DW   = 24;
  localparam int OB   = 4;

  logic          clk;
  logic          reset;
  logic [DW-1:0] sfftIn [NFFT];
  logic          iv;
  logic [DW-1:0] BinOut;
  logic [NB-1:0] BinIndex;
  logic          BinValid;
  logic          ready;
  logic          FrameStart;
  logic          FrameEnd;
  logic [15:0]   FrameCount;
  logic [7:0]    DroppedCount;
  logic          Overflow;
  logic          Busy;

  sfft_frame_reader #(
    .NFFT(NFFT), .nFFT(NB), .DATA_WIDTH(DW), .OUT_BINS(OB)
  ) dut (
    .clk(clk), .reset(reset), .SFFT_In(sfftIn), .InputValid(iv),
    .BinOut(BinOut), .BinIndex(BinIndex), .BinValid(BinValid),
    .BinReady(ready), .FrameStart(FrameStart), .FrameEnd(FrameEnd),
    .FrameCount(FrameCount), .DroppedCount(DroppedCount),
    .Overflow(Overflow), .Busy(Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [NB-1:0] i;
    logic          s;
    logic          e;
  } exp_t;

  exp_t        expQ[$];
  exp_t        cur;
  int          checks   = 0;
  int          failures = 0;
  int          occ      = 0;
  int          expDrop  = 0;
  logic [15:0] expFc    = '0;
  bit          expOv    = 0;
  bit          ivPrevM  = 0;
  bit          stallPend = 0;
  logic [DW-1:0] stOut;
  logic [NB-1:0] stIdx;
  logic          stS;
  logic          stE;

  task automatic check(input bit ok, input string nm,
                       input string act, input string req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %s required %s", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setFrame(input int base);
    for (int k = 0; k < NFFT; k++) sfftIn[k] = DW'(base + k);
  endtask

  task automatic pulse();
    iv = 1'b1;
    step();
    iv = 1'b0;
  endtask

  task automatic chkIdle(input string nm);
    bit ok;
    ok = !BinValid && BinOut == '0 && BinIndex == '0 && !FrameStart &&
         !FrameEnd && FrameCount == '0 && DroppedCount == '0 &&
         !Overflow && !Busy;
    check(ok, nm,
      $sformatf("v=%0b out=%0d idx=%0d fs=%0b fe=%0b fc=%0d dc=%0d ov=%0b busy=%0b",
        BinValid, BinOut, BinIndex, FrameStart, FrameEnd,
        FrameCount, DroppedCount, Overflow, Busy),
      "all zero");
  endtask

  task automatic drain(input string nm);
    iv    = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (expQ.size() == 0 && !Busy) break;
      step();
    end
    check(expQ.size() == 0 && !Busy, nm,
      $sformatf("pending=%0d busy=%0b", expQ.size(), Busy),
      "pending=0 busy=0");
  endtask

  // Reference model and monitor: evaluated half a cycle before each edge
  always @(negedge clk) begin
    if (reset) begin
      expQ.delete();
      occ       = 0;
      expFc     = '0;
      expDrop   = 0;
      expOv     = 0;
      ivPrevM   = 0;
      stallPend = 0;
    end else begin
      check(FrameCount == expFc && DroppedCount == 8'(expDrop) &&
            Overflow == expOv && Busy == (occ != 0), "counters",
        $sformatf("fc=%0d dc=%0d ov=%0b busy=%0b",
          FrameCount, DroppedCount, Overflow, Busy),
        $sformatf("fc=%0d dc=%0d ov=%0b busy=%0b",
          expFc, expDrop, expOv, occ != 0));
      if (stallPend) begin
        check(BinValid && BinOut == stOut && BinIndex == stIdx &&
              FrameStart == stS && FrameEnd == stE, "stall_stable",
          $sformatf("v=%0b out=%0d idx=%0d", BinValid, BinOut, BinIndex),
          $sformatf("v=1 out=%0d idx=%0d", stOut, stIdx));
      end
      if (BinValid && ready) begin
        if (expQ.size() == 0) begin
          check(0, "unexpected_beat",
            $sformatf("out=%0d idx=%0d", BinOut, BinIndex), "no beat");
        end else begin
          cur = expQ.pop_front();
          check(BinOut == cur.d && BinIndex == cur.i &&
                FrameStart == cur.s && FrameEnd == cur.e, "beat",
            $sformatf("out=%0d idx=%0d fs=%0b fe=%0b",
              BinOut, BinIndex, FrameStart, FrameEnd),
            $sformatf("out=%0d idx=%0d fs=%0b fe=%0b",
              cur.d, cur.i, cur.s, cur.e));
          if (cur.e) begin
            occ--;
            expFc++;
          end
        end
      end
      stallPend = BinValid && !ready;
      stOut = BinOut;
      stIdx = BinIndex;
      stS   = FrameStart;
      stE   = FrameEnd;
      if (iv && !ivPrevM) begin
        if (occ < 2) begin
          for (int k = 0; k < OB; k++) begin
            cur.d = sfftIn[k];
            cur.i = NB'(k);
            cur.s = (k == 0);
            cur.e = (k == OB - 1);
            expQ.push_back(cur);
          end
          occ++;
        end else begin
          if (expDrop < 255) expDrop++;
          expOv = 1;
        end
      end
      ivPrevM = iv;
    end
  end

  initial begin
    bit found;
    bit rdPat [7];
    rdPat = '{1, 0, 0, 1, 0, 1, 1};
    reset = 1'b1;
    iv    = 1'b0;
    ready = 1'b0;
    setFrame(0);
    step();
    step();
    chkIdle("reset_state");
    reset = 1'b0;
    step();

    // single frame with latency check
    ready = 1'b1;
    setFrame(100);
    iv = 1'b1;
    step();
    check(!BinValid, "latency_edge", $sformatf("v=%0b", BinValid), "v=0");
    iv = 1'b0;
    step();
    check(BinValid && BinIndex == '0 && BinOut == 24'd100 && FrameStart,
      "latency_next",
      $sformatf("v=%0b idx=%0d out=%0d fs=%0b",
        BinValid, BinIndex, BinOut, FrameStart),
      "v=1 idx=0 out=100 fs=1");
    drain("drain_single");

    // backpressure pattern
    setFrame(100);
    pulse();
    foreach (rdPat[i]) begin
      ready = rdPat[i];
      step();
    end
    drain("drain_backpressure");

    // back-to-back frames with no gap
    ready = 1'b0;
    setFrame(100);
    pulse();
    step();
    setFrame(200);
    pulse();
    step();
    step();
    check(Busy && BinValid, "b2b_busy",
      $sformatf("busy=%0b v=%0b", Busy, BinValid), "busy=1 v=1");
    ready = 1'b1;
    for (int i = 0; i < 2 * OB; i++) begin
      check(BinValid, "b2b_nogap", $sformatf("v=%0b", BinValid), "v=1");
      step();
    end
    drain("drain_b2b");

    // overflow: third frame dropped
    ready = 1'b0;
    setFrame(100);
    pulse();
    step();
    setFrame(200);
    pulse();
    step();
    setFrame(300);
    pulse();
    step();
    check(DroppedCount == 8'd1 && Overflow, "overflow",
      $sformatf("dc=%0d ov=%0b", DroppedCount, Overflow), "dc=1 ov=1");
    drain("drain_overflow");

    // held InputValid gives one capture
    ready = 1'b1;
    setFrame(50);
    iv = 1'b1;
    repeat (5) step();
    iv = 1'b0;
    drain("drain_held");

    // trigger coincident with final beat while both banks full
    ready = 1'b0;
    setFrame(10);
    pulse();
    step();
    setFrame(20);
    pulse();
    step();
    ready = 1'b1;
    step();
    step();
    step();
    setFrame(30);
    iv = 1'b1;
    step();
    iv = 1'b0;
    check(DroppedCount == 8'd1, "coincident_nodrop",
      $sformatf("dc=%0d", DroppedCount), "dc=1");
    drain("drain_coincident");

    // reset during beat 2
    ready = 1'b1;
    setFrame(70);
    pulse();
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (BinValid && BinIndex == NB'(2)) begin
        found = 1;
        break;
      end
      step();
    end
    check(found, "reach_beat2", $sformatf("found=%0b", found), "found=1");
    reset = 1'b1;
    #1;
    chkIdle("reset_async");
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check(!BinValid, "post_reset_idle", $sformatf("v=%0b", BinValid), "v=0");
      step();
    end
    setFrame(80);
    pulse();
    drain("drain_after_reset");

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      ready = ($urandom_range(0, 3) != 0);
      if (!iv && $urandom_range(0, 7) == 0) begin
        for (int k = 0; k < NFFT; k++) sfftIn[k] = DW'($urandom);
        iv = 1'b1;
      end else if (iv && $urandom_range(0, 2) == 0) begin
        iv = 1'b1;
      end else begin
        iv = 1'b0;
      end
      step();
    end
    drain("drain_random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sfft_frame_reader.md
Name: sfft_frame_reader

Overview:
Consumer end of the SFFT pipeline output interface. It captures the parallel NFFT-bin result vector whenever the pipeline pulses its output-valid signal, holding it in a two-bank frame buffer. It then streams the first OUT_BINS bins, one bin per beat, over a valid/ready handshake to the downstream peak-finder/host bridge. It decouples the pipeline's bursty full-vector output from a slower serial consumer and reports dropped frames.

Parameters:
NFFT, 256, FFT size; number of bins in the input vector (matches `NFFT)
nFFT, 8, log2(NFFT); width of bin index
DATA_WIDTH, 24, width of one bin (matches `SFFT_OUTPUT_WIDTH)
OUT_BINS, 128, number of bins streamed per frame (bins 0..OUT_BINS-1), 1 <= OUT_BINS <= NFFT

Ports:
clk  input  1  single clock
reset  input  1  asynchronous, active-high reset
SFFT_In  input  DATA_WIDTH x NFFT (unpacked array)  real-part FFT result vector from the pipeline
InputValid  input  1  pipeline OutputValid; capture is triggered on its rising edge
BinOut  output  DATA_WIDTH  current bin value
BinIndex  output  nFFT  index of current bin
BinValid  output  1  BinOut/BinIndex are valid
BinReady  input  1  downstream accepts the beat when BinValid && BinReady at posedge clk
FrameStart  output  1  high with the beat whose BinIndex == 0
FrameEnd  output  1  high with the beat whose BinIndex == OUT_BINS-1
FrameCount  output  16  completed frames streamed; wraps at 2^16
DroppedCount  output  8  frames discarded because both banks were full; saturates at 255
Overflow  output  1  sticky; set on the first dropped frame
Busy  output  1  high when at least one bank holds an undrained frame

Behaviour:
- Reset (async assert, released synchronously to clk): both banks marked empty; wrBank = rdBank = 0; read index = 0; InputValid edge register = 0. All outputs are 0.
- Trigger: capture when InputValid == 1 and its registered previous value == 0. Holding InputValid high for several cycles gives exactly one capture.
- Capture: on the trigger edge, the full SFFT_In vector is written into bank wrBank if that bank is free. The bank is then marked full and wrBank toggles.
- Drop: if no bank is free, the frame is discarded. DroppedCount increments (saturating) and Overflow is set; bank contents are untouched.
- Same-cycle free and capture: if the final beat of a frame (FrameEnd transfer) and a trigger occur at the same edge, the bank being freed counts as free. The capture succeeds into it; no drop.
- Read FSM:
  - IDLE: BinValid = 0. When bank rdBank is full, go to STREAM with index 0.
  - STREAM: BinValid = 1; BinOut = bank[rdBank][index]; BinIndex = index.
  - On a transfer with index < OUT_BINS-1: index increments.
  - On a transfer with index == OUT_BINS-1: bank rdBank is freed, rdBank toggles, index returns to 0, and FrameCount increments (wrapping).
  - After the last beat, if the other bank is already full, stay in STREAM. The next frame's bin 0 is presented on the following cycle with no bubble. Otherwise go to IDLE.
- Latency: trigger edge at posedge t with the read side idle gives BinValid = 1 after posedge t+1, so bin 0 is visible in cycle t+1. BinOut/BinIndex/FrameStart/FrameEnd are registered.
- Stall: while BinValid && !BinReady, BinOut, BinIndex, FrameStart and FrameEnd hold stable. BinValid never drops until the beat is accepted.
- FrameStart = STREAM && index == 0. FrameEnd = STREAM && index == OUT_BINS-1. Both are high together when OUT_BINS == 1.
- Busy = OR of the two bank-full flags.
- Bin values pass through unmodified (no scaling or sign change). Bins OUT_BINS..NFFT-1 are never output, though all NFFT bins are captured.
- Reset mid-frame: the stream aborts immediately, BinValid = 0, and the partial frame is lost. No beat is replayed after reset.

Test Plan:
- Bench uses NFFT=8, OUT_BINS=4, BinReady=1, SFFT_In[k]=k+100. Pulse InputValid once -> BinValid from next cycle; beats 100,101,102,103 with BinIndex 0..3; FrameStart on beat 0, FrameEnd on beat 3; FrameCount=1; Busy returns to 0.
- Backpressure: same frame, BinReady toggled 1,0,0,1,0,1,1 -> exactly 4 accepted beats in order 100..103; BinOut stable during every stalled cycle.
- Back-to-back: BinReady=0; frame A (k+100) then frame B (k+200) captured -> Busy=1. Set BinReady=1 -> 100..103 immediately followed by 200..203 with no BinValid gap; FrameCount=2.
- Overflow: BinReady=0; three triggers with frames A, B, C -> DroppedCount=1, Overflow=1; stream drains A then B; C is never seen.
- Held InputValid high for 5 cycles -> exactly one capture (FrameCount=1 after drain). Then trigger coincident with the FrameEnd transfer of a full-full state -> no drop (DroppedCount unchanged).
- Assert reset during beat 2 of a frame -> all outputs 0 asynchronously. After release with no new trigger, BinValid stays 0; the next trigger streams the new frame from BinIndex 0.
